pmem_loader: RTL
================

Name: pmem_loader

Overview:
- Writer for the program memory. Receives a byte stream carrying a length header and 16-bit instruction words, assembles the words, and drives a synchronous single-port write interface into program memory starting at address 0.
- Sits between the host/debug byte source and the pmem write port. While it is busy, the core is held off by out_busy.

Parameters:
- WORD_WIDTH, 16, memory word width in bits; fixed at 16, since exactly two bytes form one word.
- ADDR_WIDTH, 12, byte-address width of the pmem port.
- NUM_WORDS, 2048, pmem capacity in words; this is the maximum legal load length.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_byte  input  8  stream byte.
- in_byte_valid  input  1  in_byte is valid this cycle.
- out_byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when valid and ready are both high.
- out_wr_en  output  1  pmem write strobe, one cycle per word.
- out_wr_addr  output  ADDR_WIDTH  byte address of the write; LSB is always 0.
- out_wr_data  output  WORD_WIDTH  word to write.
- out_busy  output  1  high from start acceptance until DONE or ERROR is reached.
- out_done  output  1  load completed; held until the next start or reset.
- out_error  output  1  header length exceeded NUM_WORDS; held until the next start or reset.
- out_checksum  output  16  modulo-2^16 sum of all words written in the current load.

Behaviour:
- Reset: all outputs 0, state IDLE, word counter and checksum cleared. A reset asserted mid-load aborts the load immediately; the memory contents are left as written.
- States: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, DONE, ERROR.
- out_byte_ready is 1 only in LEN_LO, LEN_HI, DAT_LO and DAT_HI. It is a registered decode of state and never depends combinationally on in_byte_valid.
- IDLE/DONE/ERROR + in_start -> LEN_LO. On that edge: clear done, error, checksum and word index; set busy.
- in_start while busy is ignored.
- LEN_LO: on transfer, capture length[7:0] -> LEN_HI.
- LEN_HI: on transfer, capture length[15:8], then branch:
  - length == 0 -> DONE.
  - length > NUM_WORDS -> ERROR.
  - otherwise -> DAT_LO.
- DAT_LO: on transfer, capture low byte -> DAT_HI. Data is little-endian: low byte first.
- DAT_HI: on transfer, form word {byte, low} -> WRITE.
- WRITE: exactly one cycle with out_wr_en=1, out_wr_addr = word_index << 1, out_wr_data = the word. On the same edge: checksum += word (wraps), word_index += 1. Then:
  - if word_index+1 == length -> DONE
  - else -> DAT_LO.
- Outside WRITE: out_wr_en = 0; out_wr_addr and out_wr_data hold their last values.
- Throughput: 3 cycles per word minimum (two byte transfers plus one write cycle). Stalls on valid=0 are unbounded, and no state changes while valid=0.
- DONE: busy=0, done=1, ready=0. ERROR: busy=0, error=1, ready=0, and no writes are issued.
- Word index is ADDR_WIDTH-1 bits wide. A length of exactly NUM_WORDS writes the last word at byte address 2*(NUM_WORDS-1), with no wrap.
- Bytes presented while ready=0 are not consumed; the source must hold them.

Test Plan:
- Reset, then start; stream 02 00 34 12 CD AB -> writes (addr 0x000, 0x1234) then (addr 0x002, 0xABCD); done=1; checksum=0xBE01; busy=1 throughout the load.
- Stream 00 00 -> DONE two transfers after start; no out_wr_en pulse; checksum=0.
- Header 01 08 (length 2049) with NUM_WORDS=2048 -> error=1, done=0, no writes, ready=0 afterwards.
- Load 2048 words with random valid gaps -> 2048 single-cycle write pulses; last address 0xFFE; checksum equals the modulo-2^16 reference sum; ready is never high in WRITE.
- Assert reset after the 3rd data byte -> next cycle busy=0, ready=0, wr_en=0; a new start with 01 00 FF FF writes 0xFFFF to address 0.
- in_start pulsed mid-load -> ignored; the load completes normally. in_start pulsed in DONE -> done clears and a new load begins.

Source files
------------

// File: rtl/pmem_loader.sv
// Program-memory loader: length-prefixed little-endian byte stream -> 16-bit word writes from address 0.
// Three cycles per word minimum (two byte transfers + one write cycle); ready is low outside header/data states.
module pmem_loader #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WORDS  = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_start,
    input  logic [7:0]            in_byte,
    input  logic                  in_byte_valid,
    output logic                  out_byte_ready,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [WORD_WIDTH-1:0] out_wr_data,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error,
    output logic [15:0]           out_checksum
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [15:0] MAX_LEN = 16'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WORD_WIDTH-1:0] r_wr_data;
    logic [15:0]           r_checksum;
    logic [15:0]           r_len;
    logic [7:0]            r_lo;
    logic [IDX_W-1:0]      r_idx;

    logic        w_xfer;
    logic        w_start;
    logic [15:0] w_len_full;
    logic [15:0] w_idx_inc;

    assign w_xfer     = in_byte_valid & r_ready;
    assign w_start    = in_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
    assign w_len_full = {in_byte, r_len[7:0]};
    // Widened so that the final index of a full-capacity load does not wrap before the compare.
    assign w_idx_inc  = {{(16-IDX_W){1'b0}}, r_idx} + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (in_start) begin
                    w_state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = S_DONE;
                    end else if (w_len_full > MAX_LEN) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_DAT_LO;
                    end
                end
            end
            S_DAT_LO: begin
                if (w_xfer) begin
                    w_state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (w_xfer) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_idx_inc == r_len) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DAT_LO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they are registered and line up with r_state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_LEN_LO) | (w_state_nxt == S_LEN_HI) |
                       (w_state_nxt == S_DAT_LO) | (w_state_nxt == S_DAT_HI);
            r_busy  <= (w_state_nxt == S_LEN_LO) | (w_state_nxt == S_LEN_HI) |
                       (w_state_nxt == S_DAT_LO) | (w_state_nxt == S_DAT_HI) |
                       (w_state_nxt == S_WRITE);
            r_done  <= (w_state_nxt == S_DONE);
            r_error <= (w_state_nxt == S_ERROR);
            r_wr_en <= (w_state_nxt == S_WRITE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_checksum <= '0;
            r_len      <= '0;
            r_lo       <= '0;
            r_idx      <= '0;
        end else begin
            if (w_start) begin
                r_checksum <= '0;
                r_idx      <= '0;
            end
            case (r_state)
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= in_byte;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= in_byte;
                    end
                end
                S_DAT_LO: begin
                    if (w_xfer) begin
                        r_lo <= in_byte;
                    end
                end
                S_DAT_HI: begin
                    // Address and data are staged here so they are stable for the whole write cycle.
                    if (w_xfer) begin
                        r_wr_data <= {in_byte, r_lo};
                        r_wr_addr <= {r_idx, 1'b0};
                    end
                end
                S_WRITE: begin
                    r_checksum <= r_checksum + r_wr_data;
                    r_idx      <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_byte_ready = r_ready;
    assign out_wr_en      = r_wr_en;
    assign out_wr_addr    = r_wr_addr;
    assign out_wr_data    = r_wr_data;
    assign out_busy       = r_busy;
    assign out_done       = r_done;
    assign out_error      = r_error;
    assign out_checksum   = r_checksum;

endmodule
